hit_judge: RTL and testbench
============================

Name: hit_judge

Overview:
- Parametrised successor to the single-arrow collision checker in the DDR game datapath.
- Judges LANES button lanes against a per-beat required-lane mask during the metronome window.
- Grades each beat PERFECT/GOOD/MISS/WRONG by press timing, and keeps a combo count for the score/display logic.
- Sits between the button pins/metronome and the scoring and VGA feedback blocks.

Parameters:
- LANES, 4: number of button lanes. Bit0 = up, bit1 = down, bit2 = left, bit3 = right at the default.
- SYNC_STAGES, 2: synchroniser flops per asynchronous input (btn and window); minimum 2.
- PERFECT_CYCLES, 5000000: window-relative cycle bound for a PERFECT grade (50 ms at 100 MHz).
- TIMER_W, 26: width of the window timer; must hold PERFECT_CYCLES.
- COMBO_W, 8: width of the combo counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- btn  input  LANES  raw asynchronous buttons, active high.
- window  input  1  metronome level; high = judging window open. Asynchronous to clk.
- arrow  input  LANES  required-lane mask for the current beat. 0 = empty beat.
- judge_valid  output  1  one-cycle pulse when a judgement is issued.
- judge_grade  output  2  judgement: 00 MISS, 01 WRONG, 10 GOOD, 11 PERFECT. Holds its last value.
- combo  output  COMBO_W  consecutive GOOD/PERFECT count.
- pressed  output  LANES  lanes accumulated in the current window.

Behaviour:
- Reset (async, rst_n low):
  - state CLOSED; judge_valid, judge_grade, combo, pressed, timer, target and all synchroniser/edge flops = 0.
  - A button held across reset release produces a press edge once synchronised.
- Synchronisation and edge detection:
  - btn and window each pass through SYNC_STAGES flops plus one history flop.
  - A press is a rising edge of a synchronised btn bit; open/close are the rising/falling edges of the synchronised window.
  - All edges share the same latency, so relative ordering is preserved.
- Latency: raw btn/window change to judge_valid = SYNC_STAGES+2 clk edges.
- State CLOSED:
  - open edge: target <= arrow, pressed <= 0, timer <= 0, go to OPEN. Presses in the same cycle count toward the new window.
  - Any press without an open edge: WRONG pulse, stay CLOSED.
- State OPEN:
  - timer increments each cycle, saturating at all-ones.
  - p = pressed | press_edges; pressed <= p.
  - If p & ~target != 0: WRONG, go to DONE (also applies to any press on an empty beat).
  - Else if p == target and target != 0: PERFECT if timer < PERFECT_CYCLES else GOOD, go to DONE.
  - Else on close edge: MISS if target != 0, otherwise no judgement; go to CLOSED.
  - A completing press and a close edge in the same cycle are judged as the hit, then go to CLOSED.
- State DONE:
  - Presses are ignored; pressed holds.
  - Close edge goes to CLOSED. Open edge cannot occur before close.
- Judgement outputs:
  - Each judgement is registered: judge_valid high exactly one cycle, judge_grade updated in the same cycle.
  - At most one judgement per clock.
  - WRONG in CLOSED and a judgement in OPEN never coincide.
- Combo:
  - GOOD/PERFECT: combo + 1, saturating at 2^COMBO_W - 1.
  - MISS/WRONG: combo <= 0.
  - Updated in the same cycle as judge_valid.
- Reset mid-window: returns immediately to CLOSED with no judgement. The window must re-open (a new rising edge) before judging resumes.

Test Plan (LANES=4, SYNC_STAGES=2, PERFECT_CYCLES=8):
- Single early hit: arrow=0001, raise window, press btn[0] at window+3 cycles -> one judge_valid with grade 11, combo 0 -> 1, pressed=0001.
- Late chord: arrow=0101, press btn[0] at window+2 and btn[2] at window+12 -> grade 10 at the second press only, combo increments once.
- Wrong lane: arrow=0001, press btn[1] -> grade 01, combo -> 0; a further btn[0] press in the same window produces no pulse.
- Miss and empty beat: arrow=0011, press only btn[0], drop window -> grade 00 at close. Next beat arrow=0000 with no press -> no judge_valid, combo unchanged.
- Out-of-window press and saturation: press btn[3] while window is low -> grade 01. Preload 255 hits with COMBO_W=8 -> combo stays 255 on the next hit.
- Reset mid-window: assert rst_n low with window high and pressed=0001 -> all outputs 0 immediately. Release with window still high -> no judgement until the next window rise.

Source files
------------

// File: rtl/hit_judge_if.sv
// Button/metronome inputs and judgement outputs of the hit_judge lane checker.
interface hit_judge_if #(
  parameter int LANES   = 4,
  parameter int COMBO_W = 8
);
  logic [LANES-1:0]   btn;
  logic               window;
  logic [LANES-1:0]   arrow;
  logic               judge_valid;
  logic [1:0]         judge_grade;
  logic [COMBO_W-1:0] combo;
  logic [LANES-1:0]   pressed;

  modport master (
    output btn, window, arrow,
    input  judge_valid, judge_grade, combo, pressed
  );

  modport slave (
    input  btn, window, arrow,
    output judge_valid, judge_grade, combo, pressed
  );
endinterface

// File: rtl/hit_judge.sv
// Judges synchronised button presses against the beat's required-lane mask
// inside the metronome window; grades timing and tracks the combo count.
module hit_judge #(
  parameter int LANES          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int PERFECT_CYCLES = 5000000,
  parameter int TIMER_W        = 26,
  parameter int COMBO_W        = 8
) (
  input logic        clk,
  input logic        rst_n,
  hit_judge_if.slave bus
);

  localparam logic [1:0] G_MISS    = 2'b00;
  localparam logic [1:0] G_WRONG   = 2'b01;
  localparam logic [1:0] G_GOOD    = 2'b10;
  localparam logic [1:0] G_PERFECT = 2'b11;
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {CLOSED, OPEN, DONE} state_t;

  function automatic logic [TIMER_W-1:0] timer_inc(input logic [TIMER_W-1:0] t);
    return (&t) ? t : t + 1'b1;
  endfunction

  // Hits extend the combo (saturating); misses and wrong presses break it.
  function automatic logic [COMBO_W-1:0] combo_next(input logic [COMBO_W-1:0] c,
                                                     input logic [1:0] grade);
    if (!grade[1]) return '0;
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [SYNC_STAGES-1:0][LANES-1:0] btn_sync;
  logic [LANES-1:0]                  btn_hist;
  logic [SYNC_STAGES-1:0]            win_sync;
  logic                              win_hist;
  logic [SETTLE_W-1:0]               settle_cnt;
  logic                              win_live;
  logic [LANES-1:0]                  press_p1;
  logic                              open_p1;
  logic                              close_p1;

  logic [LANES-1:0]   btn_s;
  logic               win_s;

  assign btn_s = btn_sync[SYNC_STAGES-1];
  assign win_s = win_sync[SYNC_STAGES-1];

  // Stage p0: synchronisers, history flops and registered edge pulses.
  // win_live keeps a window already high at reset release from counting as
  // an open; it arms only after the synchronised window has been seen low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync   <= '0;
      btn_hist   <= '0;
      win_sync   <= '0;
      win_hist   <= 1'b0;
      settle_cnt <= '0;
      win_live   <= 1'b0;
      press_p1   <= '0;
      open_p1    <= 1'b0;
      close_p1   <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], bus.btn};
      btn_hist <= btn_s;
      win_sync <= {win_sync[SYNC_STAGES-2:0], bus.window};
      win_hist <= win_s;
      if (settle_cnt != SETTLE_W'(SYNC_STAGES))
        settle_cnt <= settle_cnt + 1'b1;
      else if (!win_s)
        win_live <= 1'b1;
      press_p1 <= btn_s & ~btn_hist;
      open_p1  <= win_s & ~win_hist & win_live;
      close_p1 <= ~win_s & win_hist;
    end
  end

  state_t             state_q, state_d;
  logic [LANES-1:0]   target_q, target_d;
  logic [LANES-1:0]   pressed_q, pressed_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               fire;
  logic [1:0]         grade_d;
  logic [LANES-1:0]   p;
  logic               judge_valid_q;
  logic [1:0]         judge_grade_q;
  logic [COMBO_W-1:0] combo_q;

  assign p = pressed_q | press_p1;

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    pressed_d = pressed_q;
    timer_d   = timer_q;
    fire      = 1'b0;
    grade_d   = G_MISS;
    unique case (state_q)
      CLOSED: begin
        if (open_p1) begin
          target_d  = bus.arrow;
          pressed_d = press_p1;
          timer_d   = '0;
          state_d   = OPEN;
        end else if (|press_p1) begin
          fire    = 1'b1;
          grade_d = G_WRONG;
        end
      end
      OPEN: begin
        timer_d   = timer_inc(timer_q);
        pressed_d = p;
        if (|(p & ~target_q)) begin
          fire    = 1'b1;
          grade_d = G_WRONG;
          state_d = close_p1 ? CLOSED : DONE;
        end else if ((p == target_q) && (|target_q)) begin
          fire    = 1'b1;
          grade_d = (timer_q < TIMER_W'(PERFECT_CYCLES)) ? G_PERFECT : G_GOOD;
          state_d = close_p1 ? CLOSED : DONE;
        end else if (close_p1) begin
          fire    = |target_q;
          grade_d = G_MISS;
          state_d = CLOSED;
        end
      end
      DONE: begin
        if (close_p1) state_d = CLOSED;
      end
      default: state_d = CLOSED;
    endcase
  end

  // Stage p1: beat state and the registered judgement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CLOSED;
      target_q      <= '0;
      pressed_q     <= '0;
      timer_q       <= '0;
      judge_valid_q <= 1'b0;
      judge_grade_q <= 2'b00;
      combo_q       <= '0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      pressed_q     <= pressed_d;
      timer_q       <= timer_d;
      judge_valid_q <= fire;
      if (fire) begin
        judge_grade_q <= grade_d;
        combo_q       <= combo_next(combo_q, grade_d);
      end
    end
  end

  assign bus.judge_valid = judge_valid_q;
  assign bus.judge_grade = judge_grade_q;
  assign bus.combo       = combo_q;
  assign bus.pressed     = pressed_q;

endmodule

// File: tb/tb_hit_judge.sv
// Directed scoreboard bench for hit_judge (LANES=4, SYNC_STAGES=2, PERFECT_CYCLES=8).
module tb_hit_judge;
  localparam int LANES   = 4;
  localparam int COMBO_W = 8;
  localparam int PC      = 8;

  localparam logic [1:0] G_MISS    = 2'b00;
  localparam logic [1:0] G_WRONG   = 2'b01;
  localparam logic [1:0] G_GOOD    = 2'b10;
  localparam logic [1:0] G_PERFECT = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hit_judge_if #(.LANES(LANES), .COMBO_W(COMBO_W)) bus ();

  hit_judge #(
    .LANES(LANES), .SYNC_STAGES(2), .PERFECT_CYCLES(PC),
    .TIMER_W(26), .COMBO_W(COMBO_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [1:0]         grade;
    logic [COMBO_W-1:0] combo;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int model_combo = 0;

  task automatic check(input string name, input int actual, input int required);
    vectors++;
    if (actual != required) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, required, $time);
    end
  endtask

  task automatic expect_judge(input logic [1:0] g);
    exp_t e;
    if (g[1]) model_combo = (model_combo == 255) ? 255 : model_combo + 1;
    else      model_combo = 0;
    e.grade = g;
    e.combo = COMBO_W'(model_combo);
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic hit(input logic [3:0] arr, input logic [3:0] mask, input logic [1:0] g);
    bus.arrow  = arr;
    bus.window = 1'b1;
    tick(3);
    bus.btn = mask;
    expect_judge(g);
    tick(6);
    bus.btn    = '0;
    bus.window = 1'b0;
    tick(8);
  endtask

  // Monitor: every judgement the DUT issues is matched against the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.judge_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_judge", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("judge_grade", int'(bus.judge_grade), int'(e.grade));
          check("combo", int'(bus.combo), int'(e.combo));
        end
      end
    end
  end

  initial begin
    bus.btn    = '0;
    bus.window = 1'b0;
    bus.arrow  = '0;
    rst_n      = 1'b0;
    tick(3);
    check("rst_valid", int'(bus.judge_valid), 0);
    check("rst_grade", int'(bus.judge_grade), 0);
    check("rst_combo", int'(bus.combo), 0);
    check("rst_pressed", int'(bus.pressed), 0);
    rst_n = 1'b1;
    tick(8);

    // Single early hit
    hit(4'b0001, 4'b0001, G_PERFECT);
    drain("early_hit_drain");
    check("early_hit_pressed", int'(bus.pressed), 1);
    check("early_hit_combo", int'(bus.combo), 1);

    // Late chord: only the completing press is judged
    bus.arrow  = 4'b0101;
    bus.window = 1'b1;
    tick(2);
    bus.btn = 4'b0001;
    tick(10);
    bus.btn = 4'b0101;
    expect_judge(G_GOOD);
    tick(6);
    bus.btn    = '0;
    bus.window = 1'b0;
    tick(8);
    drain("chord_drain");
    check("chord_pressed", int'(bus.pressed), 5);

    // Wrong lane, then a correct press in the same window is ignored
    bus.arrow  = 4'b0001;
    bus.window = 1'b1;
    tick(3);
    bus.btn = 4'b0010;
    expect_judge(G_WRONG);
    tick(6);
    bus.btn = '0;
    tick(3);
    bus.btn = 4'b0001;
    tick(6);
    bus.btn    = '0;
    bus.window = 1'b0;
    tick(8);
    drain("wrong_drain");
    check("wrong_pressed", int'(bus.pressed), 2);

    // Miss at close
    bus.arrow  = 4'b0011;
    bus.window = 1'b1;
    tick(3);
    bus.btn = 4'b0001;
    tick(6);
    bus.btn    = '0;
    bus.window = 1'b0;
    expect_judge(G_MISS);
    tick(8);
    drain("miss_drain");
    check("miss_pressed", int'(bus.pressed), 1);

    // Hit, then an empty beat leaves combo alone
    hit(4'b1000, 4'b1000, G_PERFECT);
    bus.arrow  = 4'b0000;
    bus.window = 1'b1;
    tick(10);
    bus.window = 1'b0;
    tick(8);
    drain("empty_drain");
    check("empty_combo", int'(bus.combo), 1);

    // Completing press and window close in the same cycle
    bus.arrow  = 4'b0010;
    bus.window = 1'b1;
    tick(4);
    bus.btn    = 4'b0010;
    bus.window = 1'b0;
    expect_judge(G_PERFECT);
    tick(8);
    bus.btn = '0;
    tick(6);
    drain("close_hit_drain");
    check("close_hit_combo", int'(bus.combo), 2);

    // Press while window is low
    bus.btn = 4'b1000;
    expect_judge(G_WRONG);
    tick(6);
    bus.btn = '0;
    tick(6);
    drain("oow_drain");
    check("oow_combo", int'(bus.combo), 0);

    // Combo saturation
    for (int i = 0; i < 256; i++) begin
      if (i[0]) hit(4'b1000, 4'b1000, G_PERFECT);
      else      hit(4'b0001, 4'b0001, G_PERFECT);
    end
    drain("sat_drain");
    check("sat_combo", int'(bus.combo), 255);

    // Reset mid-window
    bus.arrow  = 4'b0011;
    bus.window = 1'b1;
    tick(3);
    bus.btn = 4'b0001;
    tick(6);
    check("mid_pressed", int'(bus.pressed), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(bus.judge_valid), 0);
    check("mid_rst_grade", int'(bus.judge_grade), 0);
    check("mid_rst_combo", int'(bus.combo), 0);
    check("mid_rst_pressed", int'(bus.pressed), 0);
    model_combo = 0;
    bus.btn = '0;
    tick(2);
    rst_n = 1'b1;
    tick(15);
    drain("post_rst_drain");
    check("post_rst_pressed", int'(bus.pressed), 0);
    bus.window = 1'b0;
    tick(6);
    hit(4'b0011, 4'b0011, G_PERFECT);
    drain("reopen_drain");
    check("reopen_combo", int'(bus.combo), 1);
    check("reopen_pressed", int'(bus.pressed), 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
